// File: rtl/code_game_pkg.sv
// rtl/code_game_pkg.sv - shared constants, types and helpers for the code guessing game
//
// Purpose: common definitions for the secret-code checker and its score calculator.
//   DIGITS    : digits per code
//   DIGIT_W   : bits per digit
//   CODE_W    : total code width (DIGITS*DIGIT_W)
//   NUM_VALS  : number of distinct digit values
//   state_t   : checker FSM states
//   digit_t   : one code digit
//   get_digit : extract digit at position pos (position 0 = MSBs)

package code_game_pkg;

  localparam int DIGITS   = 4;
  localparam int DIGIT_W  = 2;
  localparam int CODE_W   = DIGITS * DIGIT_W;
  localparam int NUM_VALS = 1 << DIGIT_W;

  typedef enum logic [1:0] {
    ENTRY,
    SCORE,
    WIN,
    LOSE
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Position 0 is the first digit entered and lives in the most significant bits.
  function automatic digit_t get_digit(input logic [CODE_W-1:0] value, input int pos);
    return value[(DIGITS-1-pos)*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/code_score_calc.sv
// rtl/code_score_calc.sv - combinational Mastermind-style scorer
//
// Purpose: scores a complete guess against the secret code.
// Ports:
//   guess   in  CODE_W  guess, digit 0 in MSBs
//   code    in  CODE_W  secret code, digit 0 in MSBs
//   exact   out 3       positions where guess and code agree
//   partial out 3       right digit in wrong position

module code_score_calc
  import code_game_pkg::*;
(
  input  logic [CODE_W-1:0] guess,
  input  logic [CODE_W-1:0] code,
  output logic [2:0]        exact,
  output logic [2:0]        partial
);

  logic [2:0] exact_cnt;
  logic [2:0] matched_cnt;
  logic [2:0] code_cnt;
  logic [2:0] guess_cnt;

  // Total matched digits is the per-value minimum of the two histograms,
  // summed; that total already contains the exact hits, so partial is the
  // difference. Neither sum can exceed DIGITS, so 3 bits never overflow.
  always_comb begin
    exact_cnt   = 3'd0;
    matched_cnt = 3'd0;
    code_cnt    = 3'd0;
    guess_cnt   = 3'd0;

    for (int i = 0; i < DIGITS; i++) begin
      if (get_digit(guess, i) == get_digit(code, i)) begin
        exact_cnt = exact_cnt + 3'd1;
      end
    end

    for (int v = 0; v < NUM_VALS; v++) begin
      code_cnt  = 3'd0;
      guess_cnt = 3'd0;
      for (int i = 0; i < DIGITS; i++) begin
        if (get_digit(code, i) == digit_t'(v)) begin
          code_cnt = code_cnt + 3'd1;
        end
        if (get_digit(guess, i) == digit_t'(v)) begin
          guess_cnt = guess_cnt + 3'd1;
        end
      end
      matched_cnt = matched_cnt + ((code_cnt < guess_cnt) ? code_cnt : guess_cnt);
    end

    exact   = exact_cnt;
    partial = matched_cnt - exact_cnt;
  end

endmodule

// File: rtl/code_guess_checker.sv
// rtl/code_guess_checker.sv - guess entry, scoring and win/lose tracking
//
// Purpose: collects one digit per accepted strobe into a guess, scores each
// completed guess against the secret code and tracks the game outcome.
// Ports:
//   clk          in  1       clock
//   reset        in  1       synchronous, active-high
//   code         in  CODE_W  secret code, digit 0 in MSBs, stable outside reset
//   digit_valid  in  1       digit strobe, taken when digit_valid && ready
//   digit        in  DIGIT_W digit being entered
//   clear        in  1       discard partial guess (beats digit_valid)
//   ready        out 1       block accepts digits
//   entered      out 3       digits entered in current guess
//   exact        out 3       last score: exact matches
//   partial      out 3       last score: right digit, wrong place
//   score_valid  out 1       one-cycle pulse when exact/partial update
//   guesses_used out 4       completed guesses
//   win          out 1       level, game won
//   lose         out 1       level, guesses exhausted without a win

module code_guess_checker
  import code_game_pkg::*;
#(
  parameter int MAX_GUESSES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  input  logic              digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic              clear,
  output logic              ready,
  output logic [2:0]        entered,
  output logic [2:0]        exact,
  output logic [2:0]        partial,
  output logic              score_valid,
  output logic [3:0]        guesses_used,
  output logic              win,
  output logic              lose
);

  state_t            state;
  logic [CODE_W-1:0] guess;
  logic [2:0]        calc_exact;
  logic [2:0]        calc_partial;
  logic [3:0]        used_next;

  code_score_calc u_score (
    .guess   (guess),
    .code    (code),
    .exact   (calc_exact),
    .partial (calc_partial)
  );

  assign used_next = guesses_used + 4'd1;

  // Gated by reset so the input logic never sees a ready cycle while the
  // block is being cleared.
  assign ready = (state == ENTRY) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      guess        <= '0;
      entered      <= 3'd0;
      exact        <= 3'd0;
      partial      <= 3'd0;
      score_valid  <= 1'b0;
      guesses_used <= 4'd0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (clear) begin
            entered <= 3'd0;
          end else if (digit_valid) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (entered == 3'(i)) begin
                guess[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] <= digit;
              end
            end
            entered <= entered + 3'd1;
            if (entered == 3'(DIGITS - 1)) begin
              state <= SCORE;
            end
          end
        end

        SCORE: begin
          exact        <= calc_exact;
          partial      <= calc_partial;
          score_valid  <= 1'b1;
          guesses_used <= used_next;
          entered      <= 3'd0;
          // A full match on the last allowed guess still counts as a win.
          if (calc_exact == 3'(DIGITS)) begin
            state <= WIN;
            win   <= 1'b1;
          end else if (used_next == 4'(MAX_GUESSES)) begin
            state <= LOSE;
            lose  <= 1'b1;
          end else begin
            state <= ENTRY;
          end
        end

        WIN: begin
          state <= WIN;
        end

        LOSE: begin
          state <= LOSE;
        end

        default: begin
          state <= ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_guess_checker.sv
// tb/tb_code_guess_checker.sv - self-checking bench for code_guess_checker

module tb_code_guess_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] code = 8'h00;
  logic       digit_valid = 1'b0;
  logic [1:0] digit = 2'd0;
  logic       clear = 1'b0;
  logic       ready;
  logic [2:0] entered;
  logic [2:0] exact;
  logic [2:0] partial;
  logic       score_valid;
  logic [3:0] guesses_used;
  logic       win;
  logic       lose;

  int tests = 0;
  int errors = 0;
  bit checking = 1'b0;

  code_guess_checker dut (
    .clk          (clk),
    .reset        (reset),
    .code         (code),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .clear        (clear),
    .ready        (ready),
    .entered      (entered),
    .exact        (exact),
    .partial      (partial),
    .score_valid  (score_valid),
    .guesses_used (guesses_used),
    .win          (win),
    .lose         (lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scorer: greedy pairing of unmatched positions, a different
  // route to the same answer than a histogram.
  function automatic void ref_score(input int g[4], input int c[4], output int ex, output int pa);
    bit cu[4];
    bit gu[4];
    bit found;
    ex = 0;
    pa = 0;
    for (int i = 0; i < 4; i++) begin
      cu[i] = 1'b0;
      gu[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (g[i] == c[i]) begin
        ex++;
        cu[i] = 1'b1;
        gu[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      if (!gu[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!found && !cu[j] && c[j] == g[i]) begin
            cu[j] = 1'b1;
            found = 1'b1;
            pa++;
          end
        end
      end
    end
  endfunction

  function automatic void code_to_arr(input logic [7:0] v, output int a[4]);
    for (int i = 0; i < 4; i++) a[i] = int'((v >> (6 - 2 * i)) & 8'h03);
  endfunction

  // Behavioural game model, stepped on each rising edge from the sampled inputs.
  int  m_g[4];
  int  m_entered = 0;
  int  m_exact = 0;
  int  m_partial = 0;
  int  m_used = 0;
  bit  m_sv = 1'b0;
  bit  m_win = 1'b0;
  bit  m_lose = 1'b0;
  bit  m_scoring = 1'b0;
  bit  m_over = 1'b0;

  always @(posedge clk) begin
    int c[4];
    int ex;
    int pa;
    if (reset) begin
      m_entered = 0; m_exact = 0; m_partial = 0; m_used = 0;
      m_sv = 1'b0; m_win = 1'b0; m_lose = 1'b0;
      m_scoring = 1'b0; m_over = 1'b0;
    end else begin
      m_sv = 1'b0;
      if (m_scoring) begin
        code_to_arr(code, c);
        ref_score(m_g, c, ex, pa);
        m_exact = ex;
        m_partial = pa;
        m_sv = 1'b1;
        m_used++;
        m_entered = 0;
        m_scoring = 1'b0;
        if (ex == 4) begin
          m_win = 1'b1; m_over = 1'b1;
        end else if (m_used == 8) begin
          m_lose = 1'b1; m_over = 1'b1;
        end
      end else if (!m_over) begin
        if (clear) begin
          m_entered = 0;
        end else if (digit_valid) begin
          m_g[m_entered] = int'(digit);
          m_entered++;
          if (m_entered == 4) m_scoring = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("ready", int'(ready), int'(!m_scoring && !m_over && !reset));
      check("entered", int'(entered), m_entered);
      check("exact", int'(exact), m_exact);
      check("partial", int'(partial), m_partial);
      check("score_valid", int'(score_valid), int'(m_sv));
      check("guesses_used", int'(guesses_used), m_used);
      check("win", int'(win), int'(m_win));
      check("lose", int'(lose), int'(m_lose));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [7:0] new_code);
    reset = 1'b1;
    code = new_code;
    tick();
    check("rst_ready", int'(ready), 0);
    check("rst_used", int'(guesses_used), 0);
    check("rst_exact", int'(exact), 0);
    check("rst_win_lose", int'({win, lose}), 0);
    reset = 1'b0;
  endtask

  task automatic send_digit(input int d);
    digit_valid = 1'b1;
    digit = 2'(d);
    tick();
    digit_valid = 1'b0;
  endtask

  // Enters four digits, then checks the pulse timing and literal score.
  task automatic guess4(input int a, input int b, input int c, input int d,
                        input int ex, input int pa);
    send_digit(a); send_digit(b); send_digit(c); send_digit(d);
    check("sv_early", int'(score_valid), 0);
    tick();
    check("sv_pulse", int'(score_valid), 1);
    check("lit_exact", int'(exact), ex);
    check("lit_partial", int'(partial), pa);
  endtask

  initial begin : main
    int g[4];
    int c[4];
    int ex;
    int pa;

    // Pin the reference scorer with hand-worked cases.
    g = '{0, 1, 2, 3}; c = '{0, 1, 2, 3}; ref_score(g, c, ex, pa);
    check("model_4_0", ex * 10 + pa, 40);
    g = '{3, 2, 1, 0}; ref_score(g, c, ex, pa);
    check("model_0_4", ex * 10 + pa, 4);
    g = '{0, 0, 0, 0}; ref_score(g, c, ex, pa);
    check("model_1_0", ex * 10 + pa, 10);
    g = '{1, 1, 0, 0}; c = '{0, 0, 1, 1}; ref_score(g, c, ex, pa);
    check("model_swap", ex * 10 + pa, 4);
    g = '{0, 1, 1, 1}; ref_score(g, c, ex, pa);
    check("model_3_0", ex * 10 + pa, 30);

    checking = 1'b1;

    // Straight win.
    do_reset(8'h1B);
    guess4(0, 1, 2, 3, 4, 0);
    check("win1_used", int'(guesses_used), 1);
    check("win1_win", int'(win), 1);
    tick();
    check("win1_ready", int'(ready), 0);
    check("win1_sv_drop", int'(score_valid), 0);

    // All-partial, then single exact, back to entry.
    do_reset(8'h1B);
    guess4(3, 2, 1, 0, 0, 4);
    check("rev_win", int'(win), 0);
    check("rev_ready", int'(ready), 1);
    check("rev_entered", int'(entered), 0);
    guess4(0, 0, 0, 0, 1, 0);
    check("zeros_used", int'(guesses_used), 2);

    do_reset(8'h05);
    guess4(1, 1, 0, 0, 0, 4);
    guess4(0, 1, 1, 1, 3, 0);

    // Eight misses then lose; later digits ignored.
    do_reset(8'h00);
    for (int k = 0; k < 8; k++) guess4(1, 1, 1, 1, 0, 0);
    check("lose_used", int'(guesses_used), 8);
    check("lose_lose", int'(lose), 1);
    send_digit(2); send_digit(2); send_digit(2); send_digit(2);
    tick(); tick();
    check("lose_hold_used", int'(guesses_used), 8);
    check("lose_hold_entered", int'(entered), 0);

    // Win on the last allowed guess.
    do_reset(8'h00);
    for (int k = 0; k < 7; k++) guess4(1, 1, 1, 1, 0, 0);
    guess4(0, 0, 0, 0, 4, 0);
    check("last_win", int'(win), 1);
    check("last_lose", int'(lose), 0);
    check("last_used", int'(guesses_used), 8);

    // Clear beats a simultaneous digit; digits during scoring are dropped.
    do_reset(8'h1B);
    send_digit(0); send_digit(1);
    clear = 1'b1; digit_valid = 1'b1; digit = 2'd2;
    tick();
    clear = 1'b0; digit_valid = 1'b0;
    check("clear_entered", int'(entered), 0);
    send_digit(3); send_digit(2); send_digit(1);
    digit_valid = 1'b1; digit = 2'd0;
    tick();
    tick();
    digit_valid = 1'b0;
    check("busy_sv", int'(score_valid), 1);
    check("busy_exact", int'(exact), 0);
    check("busy_partial", int'(partial), 4);
    tick();
    check("busy_entered", int'(entered), 0);

    // Reset mid-entry and mid-game.
    do_reset(8'h1B);
    send_digit(0); send_digit(1); send_digit(2);
    do_reset(8'h1B);
    check("mid_entered", int'(entered), 0);
    for (int k = 0; k < 5; k++) guess4(3, 3, 3, 3, 1, 0);
    check("five_used", int'(guesses_used), 5);
    do_reset(8'h1B);
    guess4(0, 1, 2, 2, 3, 0);
    check("fresh_used", int'(guesses_used), 1);

    // Random play; digits are biased toward the code so wins occur.
    do_reset(8'($urandom_range(0, 255)));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(8'($urandom_range(0, 255)));
      end else begin
        digit_valid = ($urandom_range(0, 3) != 0);
        clear = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 1) == 0 && m_entered < 4)
          digit = 2'((code >> (6 - 2 * m_entered)) & 8'h03);
        else
          digit = 2'($urandom_range(0, 3));
        tick();
        digit_valid = 1'b0;
        clear = 1'b0;
        if (m_over && $urandom_range(0, 9) == 0) do_reset(8'($urandom_range(0, 255)));
      end
    end

    tick();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d errors %0d", tests, errors);
    $fatal(1);
  end

endmodule
